// File: rtl/tcdm_bfly_net_if.sv
// rtl/tcdm_bfly_net_if.sv - initiator- and bank-side bus bundle for tcdm_bfly_net
interface tcdm_bfly_net_if #(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32
);
  localparam int unsigned AddrW = (NumOut > 1) ? $clog2(NumOut) : 1;

  logic [AddrW-1:0]                      rr_i;
  logic [NumIn-1:0]                      req_i;
  logic [NumIn-1:0]                      gnt_o;
  logic [NumIn-1:0][AddrW-1:0]           add_i;
  logic [NumIn-1:0]                      wen_i;
  logic [NumIn-1:0][ReqDataWidth-1:0]    wdata_i;
  logic [NumIn-1:0][RespDataWidth-1:0]   rdata_o;
  logic [NumIn-1:0]                      vld_o;
  logic [NumOut-1:0]                     req_o;
  logic [NumOut-1:0]                     gnt_i;
  logic [NumOut-1:0][ReqDataWidth-1:0]   wdata_o;
  logic [NumOut-1:0][RespDataWidth-1:0]  rdata_i;

  modport slave (
    input  rr_i, req_i, add_i, wen_i, wdata_i, gnt_i, rdata_i,
    output gnt_o, rdata_o, vld_o, req_o, wdata_o
  );

  modport master (
    output rr_i, req_i, add_i, wen_i, wdata_i, gnt_i, rdata_i,
    input  gnt_o, rdata_o, vld_o, req_o, wdata_o
  );
endinterface

// File: rtl/tcdm_bfly_net.sv
// rtl/tcdm_bfly_net.sv - radix-2 butterfly request network with fixed-latency response return
// Optional simulation checks are compiled in with `define TCDM_BFLY_NET_ASSERT_EN.
module tcdm_bfly_net #(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1,
  parameter bit          ExtPrio       = 1'b0
) (
  input logic            clk_i,
  input logic            rst_i,
  tcdm_bfly_net_if.slave bus
);
  localparam int unsigned AddrW  = (NumOut > 1) ? $clog2(NumOut) : 1;
  localparam int unsigned IdxW   = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned Spread = NumOut / NumIn;

  // Per-stage node state: stage s position p, stage AddrW position = bank index.
  logic                    nv   [AddrW+1][NumOut];
  logic [AddrW-1:0]        na   [AddrW+1][NumOut];
  logic [ReqDataWidth-1:0] nd   [AddrW+1][NumOut];
  logic [IdxW-1:0]         ns   [AddrW+1][NumOut];
  logic                    conf [AddrW][NumOut];

  logic [AddrW-1:0][NumOut-1:0]       prio_q, prio_d;
  logic [NumIn-1:0]                   gnt;
  logic [NumIn-1:0]                   push;
  logic [NumOut-1:0]                  req_out;
  logic [NumOut-1:0][ReqDataWidth-1:0] wdata_out;
  logic [NumIn-1:0][RespDataWidth-1:0] rdata_out;

  logic [NumIn-1:0]            rv_q [RespLat];
  logic [NumIn-1:0]            rv_d [RespLat];
  logic [NumIn-1:0][AddrW-1:0] rb_q [RespLat];
  logic [NumIn-1:0][AddrW-1:0] rb_d [RespLat];

  always_comb begin
    int         q0, q1;
    logic       r0, r1, sel, want, pref;
    logic [AddrW-1:0] k;
    q0 = 0;
    q1 = 0;
    r0 = 1'b0;
    r1 = 1'b0;
    sel = 1'b0;
    want = 1'b0;
    pref = 1'b0;
    k = '0;
    for (int p = 0; p < NumOut; p++) begin
      nv[0][p] = 1'b0;
      na[0][p] = '0;
      nd[0][p] = '0;
      ns[0][p] = '0;
    end
    for (int j = 0; j < NumIn; j++) begin
      nv[0][j*Spread] = bus.req_i[j];
      na[0][j*Spread] = bus.add_i[j];
      nd[0][j*Spread] = bus.wdata_i[j];
      ns[0][j*Spread] = IdxW'(j);
    end
    // Stage s pairs positions differing in bit b and sets that bit from the bank index.
    for (int s = 0; s < AddrW; s++) begin
      for (int p = 0; p < NumOut; p++) begin
        q0   = p & ~(1 << (AddrW - 1 - s));
        q1   = p | (1 << (AddrW - 1 - s));
        want = p[AddrW-1-s];
        r0   = nv[s][q0] && (na[s][q0][AddrW-1-s] == want);
        r1   = nv[s][q1] && (na[s][q1][AddrW-1-s] == want);
        pref = ExtPrio ? bus.rr_i[s] : prio_q[s][p];
        sel  = (r0 && r1) ? pref : r1;
        conf[s][p]  = r0 && r1;
        nv[s+1][p]  = r0 || r1;
        na[s+1][p]  = sel ? na[s][q1] : na[s][q0];
        nd[s+1][p]  = sel ? nd[s][q1] : nd[s][q0];
        ns[s+1][p]  = sel ? ns[s][q1] : ns[s][q0];
      end
    end
    // An initiator is granted only if it is the sole survivor at its bank.
    for (int j = 0; j < NumIn; j++) begin
      k      = bus.add_i[j];
      gnt[j] = bus.req_i[j] && nv[AddrW][k] && (ns[AddrW][k] == IdxW'(j)) && bus.gnt_i[k];
    end
    prio_d = prio_q;
    for (int s = 0; s < AddrW; s++) begin
      for (int p = 0; p < NumOut; p++) begin
        if (conf[s][p] && gnt[ns[s+1][p]]) begin
          prio_d[s][p] = ~prio_q[s][p];
        end
      end
    end
    for (int p = 0; p < NumOut; p++) begin
      req_out[p]   = nv[AddrW][p];
      wdata_out[p] = nd[AddrW][p];
    end
  end

  always_comb begin
    for (int j = 0; j < NumIn; j++) begin
      push[j] = bus.req_i[j] && gnt[j] && (!bus.wen_i[j] || WriteRespOn);
    end
    rv_d[0] = push;
    rb_d[0] = bus.add_i;
    for (int i = 1; i < RespLat; i++) begin
      rv_d[i] = rv_q[i-1];
      rb_d[i] = rb_q[i-1];
    end
    for (int j = 0; j < NumIn; j++) begin
      rdata_out[j] = rv_q[RespLat-1][j] ? bus.rdata_i[rb_q[RespLat-1][j]] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
      for (int i = 0; i < RespLat; i++) begin
        rv_q[i] <= '0;
        rb_q[i] <= '0;
      end
    end else begin
      prio_q <= prio_d;
      for (int i = 0; i < RespLat; i++) begin
        rv_q[i] <= rv_d[i];
        rb_q[i] <= rb_d[i];
      end
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.req_o   = req_out;
  assign bus.wdata_o = wdata_out;
  assign bus.vld_o   = rv_q[RespLat-1];
  assign bus.rdata_o = rdata_out;

`ifdef TCDM_BFLY_NET_ASSERT_EN
  always_ff @(posedge clk_i) begin
    assert (NumIn >= 2 && (NumIn & (NumIn - 1)) == 0) else $fatal(1, "NumIn not a power of 2");
    assert ((NumOut & (NumOut - 1)) == 0) else $fatal(1, "NumOut not a power of 2");
    assert (NumOut >= NumIn) else $fatal(1, "NumOut smaller than NumIn");
    assert (RespLat >= 1) else $fatal(1, "RespLat is zero");
    if (!rst_i) begin
      for (int j = 0; j < NumIn; j++) begin
        assert (!gnt[j] || bus.req_i[j]) else $fatal(1, "grant without request on %0d", j);
        for (int i = j + 1; i < NumIn; i++) begin
          assert (!(gnt[j] && gnt[i] && bus.add_i[j] == bus.add_i[i]))
            else $fatal(1, "initiators %0d and %0d granted to one bank", j, i);
        end
      end
    end
  end
`else
  // Checks excluded from this build.
`endif
endmodule

// File: tb/tb_tcdm_bfly_net.sv
// tb/tb_tcdm_bfly_net.sv - directed bench for tcdm_bfly_net, three parameterisations on shared stimulus
module tb_tcdm_bfly_net;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        rr;
  logic [3:0]        req, wen, gnt_b;
  logic [3:0][1:0]   add;
  logic [3:0][31:0]  wdata, rdata_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  tcdm_bfly_net_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifa ();
  tcdm_bfly_net_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifb ();
  tcdm_bfly_net_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifc ();

  assign ifa.rr_i = rr;  assign ifb.rr_i = rr;  assign ifc.rr_i = rr;
  assign ifa.req_i = req; assign ifb.req_i = req; assign ifc.req_i = req;
  assign ifa.add_i = add; assign ifb.add_i = add; assign ifc.add_i = add;
  assign ifa.wen_i = wen; assign ifb.wen_i = wen; assign ifc.wen_i = wen;
  assign ifa.wdata_i = wdata; assign ifb.wdata_i = wdata; assign ifc.wdata_i = wdata;
  assign ifa.gnt_i = gnt_b; assign ifb.gnt_i = gnt_b; assign ifc.gnt_i = gnt_b;
  assign ifa.rdata_i = rdata_b; assign ifb.rdata_i = rdata_b; assign ifc.rdata_i = rdata_b;

  tcdm_bfly_net #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b0), .ExtPrio(1'b0))
    u_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  tcdm_bfly_net #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b0))
    u_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  tcdm_bfly_net #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b1))
    u_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    wen = '0;
    add = '0;
  endtask

  initial begin
    rr    = '0;
    gnt_b = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wdata[k]   = 32'hA000_0000 + k;
      rdata_b[k] = 32'hD000_0000 + k;
    end
    idle();

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_vld", ifa.vld_o, 4'h0);
    chk("reset_rdata", ifa.rdata_o, 128'h0);
    chk("reset_req_o", ifa.req_o, 4'h0);
    chk("reset_gnt_o", ifa.gnt_o, 4'h0);

    // Permutation: initiator j reads bank j
    tick();
    req = 4'hF;
    for (int j = 0; j < 4; j++) add[j] = 2'(j);
    #1;
    chk("perm_gnt", ifa.gnt_o, 4'hF);
    chk("perm_req_o", ifa.req_o, 4'hF);
    chk("perm_wdata_o", ifa.wdata_o, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    tick();
    idle();
    chk("perm_vld", ifa.vld_o, 4'hF);
    chk("perm_rdata", ifa.rdata_o, {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000});

    // Same-bank conflict: initiators 0 and 1 read bank 2
    req = 4'b0011;
    add[0] = 2'd2;
    add[1] = 2'd2;
    #1;
    chk("conf1_gnt", ifa.gnt_o, 4'b0001);
    chk("conf1_req_o", ifa.req_o, 4'b0100);
    chk("conf1_wdata_o2", ifa.wdata_o[2], 32'hA000_0000);
    tick();
    chk("conf1_vld", ifa.vld_o, 4'b0001);
    chk("conf1_rdata0", ifa.rdata_o[0], 32'hD000_0002);
    chk("conf2_gnt", ifa.gnt_o, 4'b0010);
    tick();
    idle();
    chk("conf2_vld", ifa.vld_o, 4'b0010);
    chk("conf2_rdata1", ifa.rdata_o[1], 32'hD000_0002);
    chk("conf2_rdata0", ifa.rdata_o[0], 32'h0);

    // Write: initiator 3 writes bank 1
    req = 4'b1000;
    wen = 4'b1000;
    add[3] = 2'd1;
    #1;
    chk("wr_gnt", ifa.gnt_o, 4'b1000);
    chk("wr_req_o", ifa.req_o, 4'b0010);
    chk("wr_wdata_o1", ifa.wdata_o[1], 32'hA000_0003);
    tick();
    idle();
    chk("wr_vld_noresp", ifa.vld_o, 4'h0);
    chk("wr_vld_resp", ifb.vld_o, 4'b1000);

    // Bank stall: bank 0 withholds grant from initiator 2
    gnt_b = 4'b1110;
    req = 4'b0100;
    add[2] = 2'd0;
    #1;
    chk("stall_req_o", ifa.req_o, 4'b0001);
    chk("stall_gnt", ifa.gnt_o, 4'h0);
    tick();
    chk("stall_vld", ifa.vld_o, 4'h0);
    gnt_b = 4'hF;
    #1;
    chk("release_gnt", ifa.gnt_o, 4'b0100);
    tick();
    idle();
    chk("release_vld", ifa.vld_o, 4'b0100);
    chk("release_rdata2", ifa.rdata_o[2], 32'hD000_0000);

    // External priority: initiators 0 and 1 target bank 0
    req = 4'b0011;
    add[0] = 2'd0;
    add[1] = 2'd0;
    rr = 2'b00;
    #1;
    chk("ext_rr0_gnt", ifc.gnt_o, 4'b0001);
    rr = 2'b11;
    #1;
    chk("ext_rr1_gnt", ifc.gnt_o, 4'b0010);
    chk("int_ignores_rr", ifa.gnt_o, 4'b0001);
    tick();
    idle();
    rr = 2'b00;
    chk("ext_vld", ifc.vld_o, 4'b0010);

    // Reset drops in-flight response and clears priority
    req = 4'b0011;
    add[0] = 2'd2;
    add[1] = 2'd2;
    #1;
    chk("pre_rst_gnt", ifa.gnt_o, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_cycle_gnt", ifa.gnt_o, 4'b0010);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_vld", ifa.vld_o, 4'h0);
    chk("post_rst_rdata", ifa.rdata_o, 128'h0);
    chk("post_rst_prio", ifa.gnt_o, 4'b0001);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
